// File: rtl/mem_block_responder.sv
// -----------------------------------------------------------------------------
// mem_block_responder
//
// Memory-side responder for the 128-bit block interface driven by the L1/L2
// caches. It accepts one outstanding block read or block write, waits
// LATENCY cycles, and then pulses mem_ready for a single cycle. For reads,
// mem_rdata holds the block during that cycle. Two saturating counters report
// the number of completed reads and writes.
//
// Parameters:
//   LATENCY    cycles from the request-visible cycle to the mem_ready cycle
//              (legal range 1..255)
//   DEPTH_BITS log2 of the number of stored 128-bit blocks
//   CNT_W      width of the transaction counters
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   proc_reset asynchronous active-high reset (the storage array is kept)
//   mem_read   block read request (level, held until mem_ready)
//   mem_write  block write request (level, held until mem_ready)
//   mem_addr   block address; only the low DEPTH_BITS bits select a block
//   mem_wdata  write block; valid while mem_write is high
//   mem_ready  one-cycle completion pulse
//   mem_rdata  read block; valid in the mem_ready cycle of a read
//   rd_count   completed reads, saturating
//   wr_count   completed writes, saturating
// -----------------------------------------------------------------------------
module mem_block_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_BITS = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [27:0]       mem_addr,
  input  logic [127:0]      mem_wdata,
  output logic              mem_ready,
  output logic [127:0]      mem_rdata,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  // BUSY counts down from LATENCY-2 so that RESP is entered exactly LATENCY
  // edges after the request was first seen in IDLE.
  localparam logic [7:0] LOAD_CNT = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic [7:0] cnt_reg;
  logic [7:0] cnt_next;

  // Latched transaction
  logic                  op_write_reg;
  logic [DEPTH_BITS-1:0] idx_reg;
  logic [127:0]          wdata_reg;

  // Backing store; deliberately not reset so contents survive proc_reset.
  logic [127:0] store [DEPTH];

  // Decodes from the output process
  logic                  accept;
  logic                  enter_resp;
  logic                  commit_write;
  logic [DEPTH_BITS-1:0] commit_idx;
  logic [127:0]          commit_wdata;
  logic                  store_we;

  // Address bits above the block index are ignored (aliasing).
  generate
    if (DEPTH_BITS < 28) begin : g_addr_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^mem_addr[27:DEPTH_BITS];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            cnt_next   = LOAD_CNT;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == 8'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      RESP: begin
        // Inputs are ignored here even if still asserted; the next request
        // is sampled in the following IDLE cycle.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs and datapath decodes
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_ready    = 1'b0;
    accept       = 1'b0;
    enter_resp   = 1'b0;
    commit_write = op_write_reg;
    commit_idx   = idx_reg;
    commit_wdata = wdata_reg;
    unique case (state_reg)
      IDLE: begin
        accept = mem_read || mem_write;
        // With a one-cycle latency the commit happens at the accepting edge,
        // so the live inputs are used instead of the (not yet) latched copy.
        if ((LATENCY == 1) && accept) begin
          enter_resp   = 1'b1;
          commit_write = mem_write;
          commit_idx   = mem_addr[DEPTH_BITS-1:0];
          commit_wdata = mem_wdata;
        end
      end
      BUSY: begin
        enter_resp = (cnt_reg == 8'd0);
      end
      RESP: begin
        mem_ready = 1'b1;
      end
      default: begin
        mem_ready = 1'b0;
      end
    endcase
    // An edge seen while reset is high must not commit anything.
    store_we = enter_resp && commit_write && !proc_reset;
  end

  // ---------------------------------------------------------------------------
  // Transaction latch, read-data register and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      op_write_reg <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
    end else if (accept) begin
      // Write wins when both requests are high; the read is dropped.
      op_write_reg <= mem_write;
      idx_reg      <= mem_addr[DEPTH_BITS-1:0];
      wdata_reg    <= mem_wdata;
    end
  end

  // Registered read, captured at the edge entering RESP. It holds its value
  // through write responses and idle periods.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      mem_rdata <= '0;
    end else if (enter_resp && !commit_write) begin
      mem_rdata <= store[commit_idx];
    end
  end

  // Counters advance at the edge leaving RESP.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (mem_ready) begin
      if (op_write_reg) begin
        if (wr_count != CNT_MAX) begin
          wr_count <= wr_count + CNT_ONE;
        end
      end else begin
        if (rd_count != CNT_MAX) begin
          rd_count <= rd_count + CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write port (no reset so it maps onto block RAM)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (store_we) begin
      store[commit_idx] <= commit_wdata;
    end
  end

endmodule

// File: tb/tb_mem_block_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_block_responder
//
// Two instances: dut_a with LATENCY=4 / CNT_W=16 for the table of block
// transactions and the reset-abort sequence, dut_b with LATENCY=1 / CNT_W=4
// for the back-to-back and counter saturation sequence.
// -----------------------------------------------------------------------------
module tb_mem_block_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a signals
  logic         a_rst;
  logic         a_read;
  logic         a_write;
  logic [27:0]  a_addr;
  logic [127:0] a_wdata;
  logic         a_ready;
  logic [127:0] a_rdata;
  logic [15:0]  a_rd;
  logic [15:0]  a_wr;

  // dut_b signals
  logic         b_rst;
  logic         b_read;
  logic         b_write;
  logic [27:0]  b_addr;
  logic [127:0] b_wdata;
  logic         b_ready;
  logic [127:0] b_rdata;
  logic [3:0]   b_rd;
  logic [3:0]   b_wr;

  mem_block_responder #(.LATENCY(4), .DEPTH_BITS(8), .CNT_W(16)) dut_a (
    .clk        (clk),
    .proc_reset (a_rst),
    .mem_read   (a_read),
    .mem_write  (a_write),
    .mem_addr   (a_addr),
    .mem_wdata  (a_wdata),
    .mem_ready  (a_ready),
    .mem_rdata  (a_rdata),
    .rd_count   (a_rd),
    .wr_count   (a_wr)
  );

  mem_block_responder #(.LATENCY(1), .DEPTH_BITS(8), .CNT_W(4)) dut_b (
    .clk        (clk),
    .proc_reset (b_rst),
    .mem_read   (b_read),
    .mem_write  (b_write),
    .mem_addr   (b_addr),
    .mem_wdata  (b_wdata),
    .mem_ready  (b_ready),
    .mem_rdata  (b_rdata),
    .rd_count   (b_rd),
    .wr_count   (b_wr)
  );

  localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
  localparam logic [127:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] DB = 128'hBBBB_CAFE_F00D_1234_5678_9ABC_DEF0_0BBB;
  localparam logic [127:0] DC = 128'hCCCC_0C0C_C0C0_7777_8888_9999_0000_CCCC;
  localparam logic [127:0] DX = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] DE = 128'hEEEE_1357_2468_ACE0_BDF1_0246_8ACE_EEEE;

  typedef struct {
    logic         wr;
    logic         rd;
    logic         drop;       // deassert/alter the request once BUSY
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;  // mem_rdata expected in the mem_ready cycle
    logic [15:0]  exp_wr;     // wr_count after the transaction
    logic [15:0]  exp_rd;     // rd_count after the transaction
  } vec_t;

  vec_t vecs [9];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction on dut_a, expecting mem_ready exactly 4 cycles after C0.
  task automatic a_txn(input vec_t v, input string tag);
    int k;
    a_write = v.wr;
    a_read  = v.rd;
    a_addr  = v.addr;
    a_wdata = v.wdata;
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (v.drop && i == 1) begin
        a_write = 1'b0;
        a_read  = 1'b0;
        a_addr  = a_addr ^ 28'h00000FF;
        a_wdata = '0;
      end
      if (a_ready) begin
        k = i;
        break;
      end
    end
    check({tag, " latency"}, 128'(k), 128'(4));
    check({tag, " rdata"}, a_rdata, v.exp_rdata);
    a_write = 1'b0;
    a_read  = 1'b0;
    @(posedge clk); #1;
    check({tag, " ready_gap"}, 128'(a_ready), 128'(0));
    check({tag, " wr_count"}, 128'(a_wr), 128'(v.exp_wr));
    check({tag, " rd_count"}, 128'(a_rd), 128'(v.exp_rd));
    $display("%s: wr=%0b rd=%0b addr=%07h latency=%0d rdata=%032h wr_count=%0d rd_count=%0d",
             tag, v.wr, v.rd, v.addr, k, a_rdata, a_wr, a_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;

    //          wr    rd    drop  addr        wdata exp_rdata wr     rd
    vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h0000010, D0, 128'h0, 16'd1, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 28'h0000010, '0, D0,     16'd1, 16'd1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 28'h0000105, DA, D0,     16'd2, 16'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 28'h0000005, '0, DA,     16'd2, 16'd2};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 28'h0000020, DB, DA,     16'd3, 16'd2};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 28'h0000020, '0, DB,     16'd3, 16'd3};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 28'h00000FF, DC, DB,     16'd4, 16'd3};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 28'h00001FF, '0, DC,     16'd4, 16'd4};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 28'h0000010, '0, D0,     16'd4, 16'd5};

    a_rst = 1'b1; a_read = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_rst = 1'b1; b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset a_ready", 128'(a_ready), 128'(0));
    check("reset a_rdata", a_rdata, 128'h0);
    check("reset a_rd", 128'(a_rd), 128'(0));
    check("reset a_wr", 128'(a_wr), 128'(0));
    check("reset b_ready", 128'(b_ready), 128'(0));
    check("reset b_rd", 128'(b_rd), 128'(0));
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk); #1;

    // Table of LATENCY=4 transactions
    for (int i = 0; i < 9; i++) begin
      a_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in BUSY: write of DX to 0x10 accepted at C0, reset pulsed at C0+2
    a_write = 1'b1; a_addr = 28'h0000010; a_wdata = DX;
    @(posedge clk); #1;
    check("abort C1 ready", 128'(a_ready), 128'(0));
    @(posedge clk); #1;
    a_rst   = 1'b1;
    a_write = 1'b0;
    #1;
    check("abort rst ready", 128'(a_ready), 128'(0));
    check("abort rst rdata", a_rdata, 128'h0);
    check("abort rst wr", 128'(a_wr), 128'(0));
    check("abort rst rd", 128'(a_rd), 128'(0));
    @(posedge clk); #1;
    a_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort quiet %0d", i), 128'(a_ready), 128'(0));
    end
    $display("abort: write of DX to 0x10 aborted by reset, wr_count=%0d rd_count=%0d", a_wr, a_rd);
    rv = '{1'b0, 1'b1, 1'b0, 28'h0000010, '0, D0, 16'd0, 16'd1};
    a_txn(rv, "post_abort_read");

    // LATENCY=1: single write, then a read held high for 17 transactions
    b_write = 1'b1; b_addr = 28'h0000003; b_wdata = DE;
    @(posedge clk); #1;
    check("b write ready", 128'(b_ready), 128'(1));
    b_write = 1'b0;
    @(posedge clk); #1;
    check("b write gap", 128'(b_ready), 128'(0));
    check("b wr_count", 128'(b_wr), 128'(1));
    $display("b_write: addr=0000003 wr_count=%0d", b_wr);

    b_read = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk); #1;
      check($sformatf("b ready cyc%0d", i), 128'(b_ready), 128'(i % 2));
      if (i % 2 == 1) begin
        check($sformatf("b rdata cyc%0d", i), b_rdata, DE);
        $display("b_read %0d: ready=%0b rdata=%032h rd_count=%0d", (i + 1) / 2, b_ready, b_rdata, b_rd);
      end
    end
    b_read = 1'b0;
    @(posedge clk); #1;
    check("b final ready", 128'(b_ready), 128'(0));
    check("b rd_count sat", 128'(b_rd), 128'(15));
    check("b wr_count hold", 128'(b_wr), 128'(1));
    $display("b_sat: 17 reads, rd_count=%0d", b_rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_block_responder.md
Name: mem_block_responder

Overview:
- Memory-side responder for the 128-bit block interface that the L1/L2 caches drive as initiators.
- Accepts a single outstanding block read or block write, waits a programmable latency, then pulses mem_ready for one cycle with read data.
- Sits below cacheL2 (or directly below cacheL1) in the pipelined MIPS memory hierarchy as the backing store / slow-memory model.
- Includes simple saturating read/write transaction counters for performance runs.

Parameters:
- LATENCY, 4, cycles from the request-visible cycle to the mem_ready cycle; legal range 1..255.
- DEPTH_BITS, 8, log2 of the number of 128-bit blocks stored; index = mem_addr[DEPTH_BITS-1:0].
- CNT_W, 16, width of the transaction counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- proc_reset  input  1  asynchronous, active-high reset.
- mem_read  input  1  block read request from the cache; level, held until mem_ready.
- mem_write  input  1  block write request from the cache; level, held until mem_ready.
- mem_addr  input  28  block address (word address [29:2]).
- mem_wdata  input  128  write block; valid while mem_write is high.
- mem_ready  output  1  one-cycle completion pulse for the accepted request.
- mem_rdata  output  128  read block; valid in the mem_ready cycle of a read.
- rd_count  output  CNT_W  completed reads, saturating.
- wr_count  output  CNT_W  completed writes, saturating.

Behaviour:
- Reset (async, immediate): state=IDLE; mem_ready=0; mem_rdata=0; rd_count=0; wr_count=0; latched op/addr/wdata cleared.
- Reset does not clear the storage array; its contents persist across reset and are X until first written.
- States:
  - IDLE: if mem_write or mem_read is high at the edge, latch op, mem_addr and mem_wdata. Go to RESP if LATENCY==1; otherwise load cnt=LATENCY-2 and go to BUSY.
  - BUSY: if cnt==0 go to RESP, else cnt-=1. Inputs are ignored.
  - RESP: mem_ready=1 for exactly this cycle; then IDLE unconditionally. Inputs in this cycle are ignored, even if still high.
- Timing: a request first visible in cycle C0 (state IDLE) yields mem_ready high in cycle C0+LATENCY.
- Back-to-back requests (e.g. writeback then refill) are re-sampled in the IDLE cycle after RESP, so the minimum spacing is LATENCY+1 cycles per transaction.
- Commit/capture happens at the edge that enters RESP:
  - write: store[idx] <= latched wdata;
  - read: mem_rdata <= store[idx] (registered; holds its value otherwise, including during write responses).
  - This gives read-after-write consistency: a read accepted after a write's RESP returns the new data.
- Simultaneous mem_read and mem_write in IDLE: the write takes precedence, and the read is not performed.
- Aliasing: mem_addr bits above DEPTH_BITS-1 are ignored; addresses equal modulo 2^DEPTH_BITS hit the same block.
- Request dropped or changed during BUSY: the latched transaction still completes and mem_ready still pulses.
- Counters:
  - increment at the edge leaving RESP (rd_count for reads, wr_count for writes);
  - hold at 2^CNT_W-1 once reached.
- Reset asserted in BUSY or RESP: the transaction is aborted, no storage write occurs, and mem_ready drops immediately.
- mem_ready is never high in two consecutive cycles.

Test Plan:
- Write/readback, LATENCY=4: write addr 0x0000010, wdata 0x0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978 -> mem_ready high in C0+4 only, wr_count=1. Then read addr 0x10 -> mem_ready at C0+4 with mem_rdata equal to that data, rd_count=1.
- LATENCY=1 boundary: read held continuously -> mem_ready pulses every 2 cycles, never two adjacent cycles; mem_rdata is correct on each pulse.
- Aliasing, DEPTH_BITS=8: write addr 0x0000105 with data A, then read addr 0x0000005 -> mem_rdata=A.
- Simultaneous mem_read=mem_write=1, addr 0x20, wdata B -> store[0x20]=B, wr_count+1, rd_count unchanged, mem_rdata unchanged.
- Reset mid-BUSY: write accepted at C0, proc_reset pulsed at C0+2 -> mem_ready stays 0 and counters read 0. A following read of the same addr returns the pre-reset contents, not the aborted data.
- Saturation, CNT_W=4: 17 reads -> rd_count=15.
